vedic_seq_mul_ctrl: RTL and testbench

//  Sequential wide multiplier built around ONE vedic4x4 core (i1,i2 -> Product, 4x4->8 comb).

---
 rtl/vedic_seq_mul_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_vedic_seq_mul_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vedic_seq_mul_ctrl.sv
// -----------------------------------------------------------------------------
// vedic_seq_mul_ctrl
//   Sequential unsigned multiplier, AW = 4*N_DIG bits by AW bits. It uses one
//   combinational vedic4x4 core. Each clock one pair of 4-bit digits goes
//   through the core, and the partial product is shifted and added into a
//   PW-bit accumulator. The operation is fully serial: a new operand pair is
//   accepted only when the block is idle.
//
//   Parameters
//     N_DIG      digits per operand (1..4); AW = 4*N_DIG, PW = 8*N_DIG
//
//   Ports
//     clk        clock; all state changes on the rising edge
//     rst        synchronous, active-high reset
//     in_valid   operand pair a/b is valid
//     in_ready   block can accept a pair (high only in IDLE)
//     a, b       AW-bit unsigned operands, captured at accept
//     out_valid  product is valid; held until out_ready
//     out_ready  consumer takes the product
//     product    PW-bit registered result a*b
//     busy       state is not IDLE
//
//   Optional build macro
//     VEDIC_SEQ_ZERO_SKIP_EN: a zero operand ends the operation after one
//     cycle with product 0. Without the macro, zero operands take the full
//     N_DIG^2 cycles like any other pair.
// -----------------------------------------------------------------------------

// 2x2 vedic (urdhva-tiryak) multiplier.
module vedic2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic x, y, c1, t;
    assign x    = a[1] & b[0];
    assign y    = a[0] & b[1];
    assign c1   = x & y;
    assign t    = a[1] & b[1];
    assign p[0] = a[0] & b[0];
    assign p[1] = x ^ y;
    assign p[2] = t ^ c1;
    assign p[3] = t & c1;
endmodule

// 4x4 vedic multiplier built from four 2x2 blocks and two adders.
module vedic4x4 (
    input  logic [3:0] i1,
    input  logic [3:0] i2,
    output logic [7:0] Product
);
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] mid;
    logic [5:0] hi;

    vedic2x2 u_ll (.a(i1[1:0]), .b(i2[1:0]), .p(q0));
    vedic2x2 u_hl (.a(i1[3:2]), .b(i2[1:0]), .p(q1));
    vedic2x2 u_lh (.a(i1[1:0]), .b(i2[3:2]), .p(q2));
    vedic2x2 u_hh (.a(i1[3:2]), .b(i2[3:2]), .p(q3));

    // Cross terms have weight 4. The high term has weight 16 and is joined
    // with the upper half of q0 before the final add.
    assign mid     = {1'b0, q1} + {1'b0, q2};
    assign hi      = {q3, q0[3:2]} + {1'b0, mid};
    assign Product = {hi, q0[1:0]};
endmodule

module vedic_seq_mul_ctrl #(
    parameter int N_DIG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*N_DIG-1:0]   a,
    input  logic [4*N_DIG-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*N_DIG-1:0]   product,
    output logic                 busy
);
    localparam int AW = 4 * N_DIG;
    localparam int PW = 8 * N_DIG;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_DIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [AW-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0] product_q, product_d;

    logic [3:0]    core_i1, core_i2;
    logic [7:0]    core_p;
    logic [PW-1:0] term;

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
    // A zero operand is flagged at accept. The single MUL cycle that follows
    // ends the operation, so out_valid rises after the first edge past accept.
    logic zero_q, zero_d;
`endif

    vedic4x4 u_core (.i1(core_i1), .i2(core_i2), .Product(core_p));

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
        zero_d    = zero_q;
`endif
        core_i1   = '0;
        core_i2   = '0;

        // Core inputs stay at zero outside MUL.
        if (state_q == S_MUL) begin
            core_i1 = 4'(a_q >> (4 * int'(i_q)));
            core_i2 = 4'(b_q >> (4 * int'(j_q)));
        end
        term = PW'(core_p) << (4 * (int'(i_q) + int'(j_q)));

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_MUL;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
                    zero_d  = (a == '0) || (b == '0);
`endif
                end
            end
            S_MUL: begin
                acc_d = acc_q + term;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
                if (zero_q) begin
                    product_d = '0;
                    state_d   = S_DONE;
                end else
`endif
                // j is the inner digit and i is the outer digit. The final
                // step writes the result directly, so no extra cycle is spent
                // reading acc.
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        product_d = acc_q + term;
                        state_d   = S_DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
            zero_q    <= zero_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign product   = product_q;
endmodule

// File: tb/tb_vedic_seq_mul_ctrl.sv
// Bench for vedic_seq_mul_ctrl. It instantiates N_DIG = 1, 2 and 4 and
// checks them against a plain a*b model with a latency rule.
module tb_vedic_seq_mul_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic iv1, ir1, ov1, or1, bz1;
    logic [3:0]  a1, b1;
    logic [7:0]  p1;
    logic iv2, ir2, ov2, or2, bz2;
    logic [7:0]  a2, b2;
    logic [15:0] p2;
    logic iv4, ir4, ov4, or4, bz4;
    logic [15:0] a4, b4;
    logic [31:0] p4;

    vedic_seq_mul_ctrl #(.N_DIG(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .product(p1), .busy(bz1));
    vedic_seq_mul_ctrl #(.N_DIG(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(or2), .product(p2), .busy(bz2));
    vedic_seq_mul_ctrl #(.N_DIG(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .product(p4), .busy(bz4));

    int tests = 0;
    int fails = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic get_ir(int k);
        case (k) 1: return ir1; 2: return ir2; default: return ir4; endcase
    endfunction
    function automatic logic get_ov(int k);
        case (k) 1: return ov1; 2: return ov2; default: return ov4; endcase
    endfunction
    function automatic logic get_bz(int k);
        case (k) 1: return bz1; 2: return bz2; default: return bz4; endcase
    endfunction
    function automatic logic [63:0] get_p(int k);
        case (k) 1: return 64'(p1); 2: return 64'(p2); default: return 64'(p4); endcase
    endfunction

    task automatic drive(int k, logic v, logic [15:0] a, logic [15:0] b, logic ordy);
        case (k)
            1: begin iv1 = v; a1 = a[3:0]; b1 = b[3:0]; or1 = ordy; end
            2: begin iv2 = v; a2 = a[7:0]; b2 = b[7:0]; or2 = ordy; end
            default: begin iv4 = v; a4 = a; b4 = b; or4 = ordy; end
        endcase
    endtask

    // One full operation on instance k (k = N_DIG). hold = cycles with
    // out_ready low after out_valid rises.
    task automatic run_op(int k, logic [15:0] a_in, logic [15:0] b_in, int hold);
        logic [15:0] mask, a, b;
        logic [63:0] expv, seen;
        int lat_exp, lat, n;
        mask = 16'((32'd1 << (4 * k)) - 1);
        a = a_in & mask;
        b = b_in & mask;
        expv = 64'(a) * 64'(b);
        lat_exp = k * k;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
        if (a == 16'd0 || b == 16'd0) lat_exp = 1;
`endif
        n = 0;
        while (!get_ir(k) && n < 50) begin @(posedge clk); #1; n++; end
        chk("ready_before_accept", 64'(get_ir(k)), 64'd1);
        drive(k, 1'b1, a, b, hold == 0);
        @(posedge clk); #1;
        // The captured operands must not follow later input changes.
        drive(k, 1'b0, 16'($urandom), 16'($urandom), hold == 0);
        chk("busy_after_accept", 64'(get_bz(k)), 64'd1);
        chk("ready_low_after_accept", 64'(get_ir(k)), 64'd0);
        lat = 0;
        while (!get_ov(k) && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("latency", 64'(lat), 64'(lat_exp));
        chk("product", get_p(k), expv);
        if (hold > 0) begin
            seen = get_p(k);
            drive(k, 1'b1, 16'h0011, 16'h0011, 1'b0);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk("hold_product", get_p(k), seen);
                chk("hold_valid", 64'(get_ov(k)), 64'd1);
                chk("hold_ready_low", 64'(get_ir(k)), 64'd0);
            end
            drive(k, 1'b0, 16'h0, 16'h0, 1'b1);
        end
        @(posedge clk); #1;
        chk("valid_drop", 64'(get_ov(k)), 64'd0);
        chk("ready_return", 64'(get_ir(k)), 64'd1);
        chk("busy_clear", 64'(get_bz(k)), 64'd0);
        drive(k, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        logic [15:0] pa [3];
        logic [15:0] pb [3];
        int idx, got, cyc, last_acc;
        logic rdy_pre, ov_pre;
        logic [15:0] p_pre;

        drive(1, 0, 0, 0, 0); drive(2, 0, 0, 0, 0); drive(4, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= 4; k = k * 2) begin
            chk("reset_valid", 64'(get_ov(k)), 64'd0);
            chk("reset_product", get_p(k), 64'd0);
            chk("reset_busy", 64'(get_bz(k)), 64'd0);
            chk("reset_ready", 64'(get_ir(k)), 64'd1);
        end

        // Full-scale operands, zero operand, and held output.
        run_op(2, 16'h00FF, 16'h00FF, 0);
        chk("ff_times_ff", 64'(p2), 64'h0000_FE01);
        run_op(2, 16'h0000, 16'h0037, 0);
        run_op(2, 16'h0037, 16'h0000, 0);
        run_op(2, 16'h00A5, 16'h003C, 5);
        chk("a5_times_3c", 64'(p2), 64'h0000_26AC);

        // Reset in the middle of MUL.
        drive(2, 1'b1, 16'h00FF, 16'h0002, 1'b1);
        @(posedge clk); #1;
        drive(2, 1'b0, 16'h0, 16'h0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", 64'(ov2), 64'd0);
        chk("midrst_product", 64'(p2), 64'd0);
        chk("midrst_busy", 64'(bz2), 64'd0);
        chk("midrst_ready", 64'(ir2), 64'd1);
        run_op(2, 16'h0012, 16'h0034, 0);
        chk("12_times_34", 64'(p2), 64'h0000_03A8);

        // Back-to-back operation with both handshakes held high.
        pa[0] = 16'h0F; pb[0] = 16'h0F;
        pa[1] = 16'h10; pb[1] = 16'h10;
        pa[2] = 16'hFF; pb[2] = 16'h01;
        idx = 0; got = 0; cyc = 0; last_acc = -1;
        drive(2, 1'b1, pa[0], pb[0], 1'b1);
        while (got < 3 && cyc < 100) begin
            rdy_pre = ir2; ov_pre = ov2; p_pre = p2;
            @(posedge clk); #1;
            cyc++;
            if (rdy_pre && iv2) begin
                if (last_acc >= 0) chk("b2b_accept_gap", 64'(cyc - last_acc), 64'd6);
                last_acc = cyc;
                idx++;
                if (idx < 3) drive(2, 1'b1, pa[idx], pb[idx], 1'b1);
                else drive(2, 1'b0, 16'h0, 16'h0, 1'b1);
            end
            if (ov_pre) begin
                chk("b2b_product", 64'(p_pre), 64'(pa[got]) * 64'(pb[got]));
                got++;
            end
        end
        chk("b2b_count", 64'(got), 64'd3);
        drive(2, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;

        // Random operands for N_DIG = 2.
        for (int r = 0; r < 4; r++) run_op(2, 16'($urandom), 16'($urandom), r % 2);

        // N_DIG = 1.
        run_op(1, 16'h000F, 16'h000F, 0);
        chk("f_times_f", 64'(p1), 64'h0000_00E1);
        run_op(1, 16'($urandom), 16'($urandom), 1);

        // N_DIG = 4, with a full-scale case and random operands.
        run_op(4, 16'hFFFF, 16'hFFFF, 0);
        for (int r = 0; r < 4; r++) run_op(4, 16'($urandom), 16'($urandom), r % 2);
        run_op(4, 16'h0000, 16'($urandom), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
